// File: rtl/axil_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_regbank_pkg
// Description : Shared definitions for the AXI4-Lite register bank: response
//               codes, write/read FSM state encodings and the default 32-bit
//               AXI4-Lite request/response channel structs.
//               Optional feature macro: AXIL_REGBANK_WR_PULSE_EN (see top).
// Revision    : 1.0 - initial release
// ============================================================================
package axil_regbank_pkg;

    // AXI4-Lite response codes used by this slave
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-path FSM: tracks which of AW/W has already been accepted
    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_ADDR_HELD = 2'd1,
        W_DATA_HELD = 2'd2,
        W_RESP      = 2'd3
    } wr_state_e;

    // Read-path FSM
    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    // Default 32-bit AXI4-Lite channel structs; the top's struct type
    // parameters default to these so the block elaborates standalone.
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } axil_ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } axil_w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } axil_b_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } axil_r_chan_t;

    typedef struct packed {
        axil_ax_chan_t aw;
        logic          aw_valid;
        axil_w_chan_t  w;
        logic          w_valid;
        logic          b_ready;
        axil_ax_chan_t ar;
        logic          ar_valid;
        logic          r_ready;
    } axil_req_t;

    typedef struct packed {
        logic          aw_ready;
        logic          w_ready;
        axil_b_chan_t  b;
        logic          b_valid;
        logic          ar_ready;
        axil_r_chan_t  r;
        logic          r_valid;
    } axil_resp_t;

    // Map an address range check onto the AXI response code
    function automatic logic [1:0] resp_code(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_regbank_decode.sv
`default_nettype none
// ============================================================================
// Module      : axil_regbank_decode
// Description : Address decoder for the register bank. Extracts the register
//               index (byte-lane offset bits ignored) and flags whether the
//               address falls inside the implemented register window.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_regbank_decode #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic [ADDR_WIDTH-1:0]       addr_i,
    output logic [$clog2(NUM_REGS)-1:0] idx_o,
    output logic                        in_range_o
);

    localparam int unsigned c_idx_w   = $clog2(NUM_REGS);
    localparam int unsigned c_off_w   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned c_top_lsb = c_off_w + c_idx_w;

    logic w_unused_lane;

    // Register index sits directly above the byte-lane offset bits
    assign idx_o = addr_i[c_off_w +: c_idx_w];

    // Any set bit above the index field means the address is past the bank
    generate
        if (ADDR_WIDTH > c_top_lsb) begin : g_range_chk
            assign in_range_o = ~|addr_i[ADDR_WIDTH-1:c_top_lsb];
        end else begin : g_range_full
            assign in_range_o = 1'b1;
        end
    endgenerate

    // Byte-lane offset bits do not select anything
    assign w_unused_lane = &{1'b0, addr_i[c_off_w-1:0]};

endmodule
`default_nettype wire

// File: rtl/axil_regbank.sv
`default_nettype none
// ============================================================================
// Module      : axil_regbank
// Description : AXI4-Lite slave register bank of NUM_REGS x DATA_WIDTH
//               registers. Independent write (AW/W/B) and read (AR/R) paths,
//               per-byte write strobes, SLVERR for out-of-range addresses.
//               Optional macro AXIL_REGBANK_WR_PULSE_EN adds wr_pulse_o, a
//               one-cycle per-register "was written" strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_regbank
    import axil_regbank_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16,
    parameter type axi_req_t  = axil_req_t,
    parameter type axi_resp_t = axil_resp_t
) (
    input  logic                                clk_i,
    input  logic                                arst_ni,
    input  axi_req_t                            axi_req_i,
    output axi_resp_t                           axi_resp_o,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_q_o
`ifdef AXIL_REGBANK_WR_PULSE_EN
    ,
    output logic [NUM_REGS-1:0]                 wr_pulse_o
`endif
);

    localparam int unsigned c_idx_w  = $clog2(NUM_REGS);
    localparam int unsigned c_strb_w = DATA_WIDTH / 8;

    // Write path state
    wr_state_e                           wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0]               aw_addr_q,  aw_addr_d;
    logic [DATA_WIDTH-1:0]               w_data_q,   w_data_d;
    logic [c_strb_w-1:0]                 w_strb_q,   w_strb_d;
    logic [1:0]                          b_resp_q,   b_resp_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q,     regs_d;

    // Read path state
    rd_state_e                           rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0]               r_data_q,   r_data_d;
    logic [1:0]                          r_resp_q,   r_resp_d;

    logic                  w_awready, w_wready, w_arready;
    logic                  w_aw_hs, w_w_hs, w_ar_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [c_strb_w-1:0]   w_wr_strb;
    logic [c_idx_w-1:0]    w_wr_idx, w_rd_idx;
    logic                  w_wr_in_range, w_rd_in_range;
    logic                  w_unused_prot;

    // Ready signals are pure functions of FSM state
    assign w_awready = (wr_state_q == W_IDLE) || (wr_state_q == W_DATA_HELD);
    assign w_wready  = (wr_state_q == W_IDLE) || (wr_state_q == W_ADDR_HELD);
    assign w_arready = (rd_state_q == R_IDLE);

    assign w_aw_hs = axi_req_i.aw_valid & w_awready;
    assign w_w_hs  = axi_req_i.w_valid  & w_wready;
    assign w_ar_hs = axi_req_i.ar_valid & w_arready;

    // Commit on the edge that completes the second (or simultaneous) handshake
    assign w_commit = ((wr_state_q == W_IDLE)      && w_aw_hs && w_w_hs) ||
                      ((wr_state_q == W_ADDR_HELD) && w_w_hs)            ||
                      ((wr_state_q == W_DATA_HELD) && w_aw_hs);

    // Whichever half arrived first comes from the holding flops
    assign w_wr_addr = (wr_state_q == W_ADDR_HELD) ? aw_addr_q : axi_req_i.aw.addr;
    assign w_wr_data = (wr_state_q == W_DATA_HELD) ? w_data_q  : axi_req_i.w.data;
    assign w_wr_strb = (wr_state_q == W_DATA_HELD) ? w_strb_q  : axi_req_i.w.strb;

    // Protection attributes are accepted but carry no meaning here
    assign w_unused_prot = ^{axi_req_i.aw.prot, axi_req_i.ar.prot};

    axil_regbank_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_wr_decode (
        .addr_i     (w_wr_addr),
        .idx_o      (w_wr_idx),
        .in_range_o (w_wr_in_range)
    );

    axil_regbank_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_rd_decode (
        .addr_i     (axi_req_i.ar.addr),
        .idx_o      (w_rd_idx),
        .in_range_o (w_rd_in_range)
    );

    // Write FSM next-state, holding registers and B response
    always_comb begin
        wr_state_d = wr_state_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        b_resp_d   = b_resp_q;

        if (w_commit) begin
            wr_state_d = W_RESP;
            b_resp_d   = resp_code(w_wr_in_range);
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        wr_state_d = W_ADDR_HELD;
                        aw_addr_d  = axi_req_i.aw.addr;
                    end else if (w_w_hs) begin
                        wr_state_d = W_DATA_HELD;
                        w_data_d   = axi_req_i.w.data;
                        w_strb_d   = axi_req_i.w.strb;
                    end
                end
                W_ADDR_HELD: wr_state_d = W_ADDR_HELD;
                W_DATA_HELD: wr_state_d = W_DATA_HELD;
                W_RESP: begin
                    if (axi_req_i.b_ready) begin
                        wr_state_d = W_IDLE;
                    end
                end
                default: wr_state_d = W_IDLE;
            endcase
        end
    end

    // Byte-strobed register update at commit; out-of-range writes are dropped
    always_comb begin
        regs_d = regs_q;
        if (w_commit && w_wr_in_range) begin
            for (int b = 0; b < int'(c_strb_w); b++) begin
                if (w_wr_strb[b]) begin
                    regs_d[w_wr_idx][8*b +: 8] = w_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read FSM: capture data/resp at the AR handshake, hold until accepted
    always_comb begin
        rd_state_d = rd_state_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (w_ar_hs) begin
                    rd_state_d = R_RESP;
                    r_data_d   = w_rd_in_range ? regs_q[w_rd_idx] : '0;
                    r_resp_d   = resp_code(w_rd_in_range);
                end
            end
            R_RESP: begin
                if (axi_req_i.r_ready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write path and register array state
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_state_q <= W_IDLE;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_resp_q   <= RESP_OKAY;
            regs_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_resp_q   <= b_resp_d;
            regs_q     <= regs_d;
        end
    end

    // Read path state
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rd_state_q <= R_IDLE;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    // Drive the response struct from registered state only
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = w_awready;
        axi_resp_o.w_ready  = w_wready;
        axi_resp_o.b_valid  = (wr_state_q == W_RESP);
        axi_resp_o.b.resp   = b_resp_q;
        axi_resp_o.ar_ready = w_arready;
        axi_resp_o.r_valid  = (rd_state_q == R_RESP);
        axi_resp_o.r.data   = r_data_q;
        axi_resp_o.r.resp   = r_resp_q;
    end

    assign reg_q_o = regs_q;

`ifdef AXIL_REGBANK_WR_PULSE_EN
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

    // Flag the register touched by a committing, non-empty in-range write
    always_comb begin
        wr_pulse_d = '0;
        if (w_commit && w_wr_in_range && (|w_wr_strb)) begin
            wr_pulse_d[w_wr_idx] = 1'b1;
        end
    end

    // Pulse appears in the cycle after the commit edge
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign wr_pulse_o = wr_pulse_q;
`else
    // Write-strobe output not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_axil_regbank.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_regbank
// Description : Directed self-checking bench for axil_regbank (16 x 32-bit).
//               Honors AXIL_REGBANK_WR_PULSE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_regbank;
    import axil_regbank_pkg::*;

    logic             clk = 1'b0;
    logic             arst_n;
    axil_req_t        req;
    axil_resp_t       resp;
    logic [15:0][31:0] reg_q;
`ifdef AXIL_REGBANK_WR_PULSE_EN
    logic [15:0]      wr_pulse;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_regs [16];

    always #5 clk = ~clk;

    axil_regbank #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .axi_req_t  (axil_req_t),
        .axi_resp_t (axil_resp_t)
    ) dut (
        .clk_i      (clk),
        .arst_ni    (arst_n),
        .axi_req_i  (req),
        .axi_resp_o (resp),
        .reg_q_o    (reg_q)
`ifdef AXIL_REGBANK_WR_PULSE_EN
        ,
        .wr_pulse_o (wr_pulse)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_regs(input string tag);
        logic [15:0][31:0] e;
        for (int i = 0; i < 16; i++) e[i] = exp_regs[i];
        n_cmp++;
        assert (reg_q === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, reg_q, e);
        end
    endtask

    // AW and W presented together, B accepted as soon as it appears
    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [1:0] bresp);
        int n;
        n = 0;
        req.aw.addr  = addr;
        req.aw_valid = 1'b1;
        req.w.data   = data;
        req.w.strb   = strb;
        req.w_valid  = 1'b1;
        req.b_ready  = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        while (!resp.b_valid && n < 8) begin
            tick();
            n++;
        end
        chk("wr_b_valid", resp.b_valid, 1);
`ifdef AXIL_REGBANK_WR_PULSE_EN
        chk("wr_pulse", wr_pulse,
            (addr < 32'h40 && strb != 4'h0) ? (16'h1 << addr[5:2]) : 16'h0);
`endif
        bresp = resp.b.resp;
        tick();
        req.b_ready = 1'b0;
        chk("wr_b_done", resp.b_valid, 0);
        chk("wr_aw_ready_after", resp.aw_ready, 1);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data,
                      output logic [1:0] rresp);
        int n;
        n = 0;
        req.ar.addr  = addr;
        req.ar_valid = 1'b1;
        req.r_ready  = 1'b1;
        tick();
        req.ar_valid = 1'b0;
        while (!resp.r_valid && n < 8) begin
            tick();
            n++;
        end
        chk("rd_r_valid", resp.r_valid, 1);
        chk("rd_ar_ready_busy", resp.ar_ready, 0);
        data  = resp.r.data;
        rresp = resp.r.resp;
        tick();
        req.r_ready = 1'b0;
        chk("rd_r_done", resp.r_valid, 0);
        chk("rd_ar_ready_after", resp.ar_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rsp;
        logic [31:0] d;

        req    = '0;
        arst_n = 1'b0;
        for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;

        // Reset values
        #23;
        chk("rst_aw_ready", resp.aw_ready, 1);
        chk("rst_w_ready",  resp.w_ready, 1);
        chk("rst_ar_ready", resp.ar_ready, 1);
        chk("rst_b_valid",  resp.b_valid, 0);
        chk("rst_r_valid",  resp.r_valid, 0);
        chk("rst_b_resp",   resp.b.resp, 0);
        chk("rst_r_data",   resp.r.data, 0);
        chk("rst_r_resp",   resp.r.resp, 0);
        chk_regs("rst_regs");
        #4 arst_n = 1'b1;
        tick();

        // Full write, AW/W together
        wr(32'h08, 32'hDEADBEEF, 4'hF, rsp);
        chk("w08_resp", rsp, 2'b00);
        exp_regs[2] = 32'hDEADBEEF;
        chk_regs("w08_regs");
        rd(32'h08, d, rsp);
        chk("r08_data", d, 32'hDEADBEEF);
        chk("r08_resp", rsp, 2'b00);
        rd(32'h0B, d, rsp);
        chk("r0b_lane_ignored", d, 32'hDEADBEEF);

        // W three cycles ahead of AW, partial strobe
        req.w.data  = 32'h12345678;
        req.w.strb  = 4'h3;
        req.w_valid = 1'b1;
        tick();
        req.w_valid = 1'b0;
        chk("wfirst_aw_ready", resp.aw_ready, 1);
        chk("wfirst_w_ready",  resp.w_ready, 0);
        chk("wfirst_b_valid",  resp.b_valid, 0);
        chk("wfirst_no_commit", reg_q[1], 32'h0);
        tick();
        tick();
        req.aw.addr  = 32'h04;
        req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        chk("wfirst_b_valid_on", resp.b_valid, 1);
        chk("wfirst_b_resp", resp.b.resp, 2'b00);
        exp_regs[1] = 32'h00005678;
        chk_regs("wfirst_regs");
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        chk("wfirst_b_taken", resp.b_valid, 0);
        tick();
        tick();
        chk("wfirst_single_b", resp.b_valid, 0);

        // Out-of-range access and last in-range register
        rd(32'h40, d, rsp);
        chk("r40_resp", rsp, 2'b10);
        chk("r40_data", d, 32'h0);
        wr(32'h40, 32'hFFFFFFFF, 4'hF, rsp);
        chk("w40_resp", rsp, 2'b10);
        chk_regs("w40_no_change");
        wr(32'h3C, 32'h13579BDF, 4'hF, rsp);
        chk("w3c_resp", rsp, 2'b00);
        exp_regs[15] = 32'h13579BDF;
        chk_regs("w3c_regs");
        rd(32'h3F, d, rsp);
        chk("r3f_data", d, 32'h13579BDF);
        chk("r3f_resp", rsp, 2'b00);

        // Read sampled on the same edge as a commit to the same register
        wr(32'h08, 32'h00000001, 4'hF, rsp);
        exp_regs[2] = 32'h1;
        req.aw.addr  = 32'h08;
        req.w.data   = 32'hA5A5A5A5;
        req.w.strb   = 4'hF;
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
        req.ar.addr  = 32'h08;
        req.ar_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        req.ar_valid = 1'b0;
        chk("race_r_valid", resp.r_valid, 1);
        chk("race_r_old", resp.r.data, 32'h1);
        chk("race_b_valid", resp.b_valid, 1);
        chk("race_reg_new", reg_q[2], 32'hA5A5A5A5);
        exp_regs[2] = 32'hA5A5A5A5;
        tick();
        chk("race_r_held", resp.r.data, 32'h1);
        req.r_ready = 1'b1;
        req.b_ready = 1'b1;
        tick();
        req.r_ready = 1'b0;
        req.b_ready = 1'b0;
        chk("race_r_taken", resp.r_valid, 0);
        chk("race_b_taken", resp.b_valid, 0);
        rd(32'h08, d, rsp);
        chk("race_reread", d, 32'hA5A5A5A5);

        // B back-pressure with a concurrent read
        req.aw.addr  = 32'h0C;
        req.w.data   = 32'h0BADF00D;
        req.w.strb   = 4'hF;
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        chk("bp_b_valid_1", resp.b_valid, 1);
        chk("bp_aw_ready_1", resp.aw_ready, 0);
        chk("bp_w_ready_1", resp.w_ready, 0);
        rd(32'h08, d, rsp);
        chk("bp_rd_data", d, 32'hA5A5A5A5);
        chk("bp_b_valid_3", resp.b_valid, 1);
        chk("bp_b_resp_3", resp.b.resp, 2'b00);
        tick();
        tick();
        chk("bp_b_valid_5", resp.b_valid, 1);
        chk("bp_aw_ready_5", resp.aw_ready, 0);
        chk("bp_w_ready_5", resp.w_ready, 0);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        chk("bp_b_taken", resp.b_valid, 0);
        chk("bp_aw_ready_back", resp.aw_ready, 1);
        exp_regs[3] = 32'h0BADF00D;
        chk_regs("bp_regs");

        // Strobe handling: single lane, then empty strobe
        wr(32'h0C, 32'hFFFFFFFF, 4'b0100, rsp);
        exp_regs[3] = 32'h0BFFF00D;
        chk_regs("strb_lane2");
        wr(32'h0C, 32'h00000000, 4'b0000, rsp);
        chk("strb0_resp", rsp, 2'b00);
        chk_regs("strb0_no_change");

        // Reset while the address is held
        req.aw.addr  = 32'h10;
        req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        chk("arst_addr_held_w_ready", resp.w_ready, 1);
        chk("arst_addr_held_aw_ready", resp.aw_ready, 0);
        arst_n = 1'b0;
        #2;
        for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
        chk_regs("arst_regs");
        chk("arst_aw_ready", resp.aw_ready, 1);
        #2 arst_n = 1'b1;
        req.b_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("arst_no_b", resp.b_valid, 0);
        chk_regs("arst_no_commit");
        req.b_ready = 1'b0;
        wr(32'h10, 32'h55AA55AA, 4'hF, rsp);
        chk("arst_next_resp", rsp, 2'b00);
        exp_regs[4] = 32'h55AA55AA;
        chk_regs("arst_next_regs");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
